// File: rtl/counter_pkg.sv
// Shared types and default sizes for the down_timer block.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_PSC_W = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Tick divider for down_timer: one tick every i_prescale+1 enabled clocks.
module tick_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [PSC_W-1:0] i_prescale,
    output logic             o_tick
);

    logic [PSC_W-1:0] psc_q;

    // >= keeps the divider from running a full wrap if i_prescale shrinks mid-count
    assign o_tick = i_en && (psc_q >= i_prescale);

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            psc_q <= '0;
        end else if (i_clr) begin
            psc_q <= '0;
        end else if (i_en) begin
            if (o_tick) begin
                psc_q <= '0;
            end else begin
                psc_q <= psc_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter timer with one-shot and auto-reload modes.
// Optional tick prescaler is built when DOWN_TIMER_PRESCALER_EN is defined.
module down_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PSC_W = DEF_PSC_W
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst_n,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_periodic,
`ifdef DOWN_TIMER_PRESCALER_EN
    input  logic [PSC_W-1:0] i_prescale,
`endif
    output logic [WIDTH-1:0] o_cnt_data,
    output logic             o_busy,
    output logic             o_tc,
    output logic             o_done,
    output state_t           o_dbg_state
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             tick;

`ifdef DOWN_TIMER_PRESCALER_EN
    tick_prescaler #(
        .PSC_W(PSC_W)
    ) u_tick_prescaler (
        .i_sysclk   (i_sysclk),
        .i_sysrst_n (i_sysrst_n),
        .i_clr      (i_ld | i_stop | i_start),
        .i_en       (state_q == RUN),
        .i_prescale (i_prescale),
        .o_tick     (tick)
    );
`else
    // Every RUN clock is a tick; PSC_W only matters to the prescaled build.
    assign tick = (state_q == RUN) && (PSC_W > 0);
`endif

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Control priority: load, stop, start, then counting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (i_ld) begin
            reload_d = i_ld_data;
            cnt_d    = i_ld_data;
            state_d  = IDLE;
        end else if (i_stop) begin
            state_d = IDLE;
        end else if (i_start) begin
            cnt_d   = reload_q;
            state_d = RUN;
        end else if (state_q == RUN && tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                tc_d = 1'b1;
                if (i_periodic) begin
                    cnt_d = reload_q;
                end else begin
                    state_d = DONE;
                end
            end
        end
        if (!(state_q inside {IDLE, RUN, DONE})) begin
            state_d = IDLE;
        end
    end

    assign o_cnt_data  = cnt_q;
    assign o_busy      = (state_q == RUN);
    assign o_done      = (state_q == DONE);
    assign o_tc        = tc_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: scripted expectations queued per clock.
module tb_down_timer;
    import counter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ld;
    logic [15:0] ld_data;
    logic        start;
    logic        stop;
    logic        periodic;
`ifdef DOWN_TIMER_PRESCALER_EN
    logic [7:0]  prescale;
`endif
    logic [15:0] cnt_data;
    logic        busy;
    logic        tc;
    logic        done;
    state_t      dbg_state;

    logic [20:0] obs_vec;
    logic [20:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    down_timer #(
        .WIDTH(16),
        .PSC_W(8)
    ) dut (
        .i_sysclk    (clk),
        .i_sysrst_n  (rst_n),
        .i_ld        (ld),
        .i_ld_data   (ld_data),
        .i_start     (start),
        .i_stop      (stop),
        .i_periodic  (periodic),
`ifdef DOWN_TIMER_PRESCALER_EN
        .i_prescale  (prescale),
`endif
        .o_cnt_data  (cnt_data),
        .o_busy      (busy),
        .o_tc        (tc),
        .o_done      (done),
        .o_dbg_state (dbg_state)
    );

    assign obs_vec = {dbg_state, busy, done, tc, cnt_data};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] ex(input state_t s, input logic t, input logic [15:0] c);
        return {s, logic'(s == RUN), logic'(s == DONE), t, c};
    endfunction

    // Push the expected post-edge outputs, clock once, then pop and compare.
    task automatic step(input string tag, input logic [20:0] exp);
        logic [20:0] e;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, 32'(obs_vec), 32'(e));
        ld    = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_ld(input string tag, input logic [15:0] d, input logic [20:0] exp);
        ld      = 1'b1;
        ld_data = d;
        step(tag, exp);
    endtask

    task automatic do_start(input string tag, input logic [20:0] exp);
        start = 1'b1;
        step(tag, exp);
    endtask

    initial begin
        int r;
        rst_n    = 1'b0;
        ld       = 1'b0;
        ld_data  = '0;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
`ifdef DOWN_TIMER_PRESCALER_EN
        prescale = 8'd0;
`endif
        #3;
        check("reset_state", 32'(obs_vec), 32'(ex(IDLE, 1'b0, 16'd0)));
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot: ld 3 -> 3,2,1,0 then tc with DONE
        do_ld("os_ld", 16'd3, ex(IDLE, 1'b0, 16'd3));
        do_start("os_start", ex(RUN, 1'b0, 16'd3));
        step("os_cnt2", ex(RUN, 1'b0, 16'd2));
        step("os_cnt1", ex(RUN, 1'b0, 16'd1));
        step("os_cnt0", ex(RUN, 1'b0, 16'd0));
        step("os_tc", ex(DONE, 1'b1, 16'd0));
        step("os_hold", ex(DONE, 1'b0, 16'd0));

        // Periodic: ld 2 -> tc every 3 clocks, 4 pulses in 12 clocks
        periodic = 1'b1;
        do_ld("per_ld", 16'd2, ex(IDLE, 1'b0, 16'd2));
        do_start("per_start", ex(RUN, 1'b0, 16'd2));
        for (int p = 0; p < 4; p++) begin
            step("per_cnt1", ex(RUN, 1'b0, 16'd1));
            step("per_cnt0", ex(RUN, 1'b0, 16'd0));
            step("per_tc", ex(RUN, 1'b1, 16'd2));
        end

        // Periodic with reload 0 -> tc every clock
        do_ld("per0_ld", 16'd0, ex(IDLE, 1'b0, 16'd0));
        do_start("per0_start", ex(RUN, 1'b0, 16'd0));
        for (int p = 0; p < 4; p++) begin
            step("per0_tc", ex(RUN, 1'b1, 16'd0));
        end
        periodic = 1'b0;

        // Simultaneous controls
        ld      = 1'b1;
        ld_data = 16'd5;
        start   = 1'b1;
        step("ld_start", ex(IDLE, 1'b0, 16'd5));
        do_start("sim_start", ex(RUN, 1'b0, 16'd5));
        step("sim_cnt4", ex(RUN, 1'b0, 16'd4));
        stop  = 1'b1;
        start = 1'b1;
        step("stop_start", ex(IDLE, 1'b0, 16'd4));
        step("stop_hold", ex(IDLE, 1'b0, 16'd4));

        // Restart at counter 1, then start again from DONE
        do_ld("rs_ld", 16'd3, ex(IDLE, 1'b0, 16'd3));
        do_start("rs_start", ex(RUN, 1'b0, 16'd3));
        step("rs_cnt2", ex(RUN, 1'b0, 16'd2));
        step("rs_cnt1", ex(RUN, 1'b0, 16'd1));
        do_start("rs_restart", ex(RUN, 1'b0, 16'd3));
        step("rs_cnt2b", ex(RUN, 1'b0, 16'd2));
        step("rs_cnt1b", ex(RUN, 1'b0, 16'd1));
        step("rs_cnt0b", ex(RUN, 1'b0, 16'd0));
        step("rs_tc", ex(DONE, 1'b1, 16'd0));
        do_start("rs_from_done", ex(RUN, 1'b0, 16'd3));
        stop = 1'b1;
        step("rs_stop", ex(IDLE, 1'b0, 16'd3));

        // Random one-shot reloads
        for (int k = 0; k < 3; k++) begin
            r = $urandom_range(0, 6);
            do_ld("rnd_ld", 16'(r), ex(IDLE, 1'b0, 16'(r)));
            do_start("rnd_start", ex(RUN, 1'b0, 16'(r)));
            for (int i = 1; i <= r; i++) begin
                step("rnd_cnt", ex(RUN, 1'b0, 16'(r - i)));
            end
            step("rnd_tc", ex(DONE, 1'b1, 16'd0));
            step("rnd_hold", ex(DONE, 1'b0, 16'd0));
        end

        // Asynchronous reset mid-count clears count and reload
        do_ld("rst_ld", 16'd4, ex(IDLE, 1'b0, 16'd4));
        do_start("rst_start", ex(RUN, 1'b0, 16'd4));
        step("rst_cnt3", ex(RUN, 1'b0, 16'd3));
        rst_n = 1'b0;
        #2;
        check("rst_async", 32'(obs_vec), 32'(ex(IDLE, 1'b0, 16'd0)));
        #1;
        rst_n = 1'b1;
        step("rst_after", ex(IDLE, 1'b0, 16'd0));
        do_start("rst_restart", ex(RUN, 1'b0, 16'd0));
        step("rst_tc", ex(DONE, 1'b1, 16'd0));

`ifdef DOWN_TIMER_PRESCALER_EN
        // Prescale 3, ld 1: tc lands 8 clocks after start
        prescale = 8'd3;
        do_ld("psc_ld", 16'd1, ex(IDLE, 1'b0, 16'd1));
        do_start("psc_start", ex(RUN, 1'b0, 16'd1));
        for (int i = 0; i < 3; i++) begin
            step("psc_hold1", ex(RUN, 1'b0, 16'd1));
        end
        for (int i = 0; i < 4; i++) begin
            step("psc_hold0", ex(RUN, 1'b0, 16'd0));
        end
        step("psc_tc", ex(DONE, 1'b1, 16'd0));
        prescale = 8'd0;
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
